// File: rtl/panel_ctrl.sv
// ============================================================================
// panel_ctrl: front-panel HALT/STEP/RUN button conditioning for the DekatronPC
// core. Sync, debounce, edge-detect, gate on core state, STEP auto-repeat.
// Revision: 1.0
// ============================================================================
`default_nettype none

module panel_ctrl #(
    parameter int         DEBOUNCE      = 16,
    parameter int         REPEAT_DELAY  = 1000,
    parameter int         REPEAT_PERIOD = 250,
    parameter logic [2:0] HALT_CODE     = 3'b100
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       BtnHalt_n,
    input  logic       BtnStep_n,
    input  logic       BtnRun_n,
    input  logic [2:0] CpuState,
    output logic       Halt,
    output logic       Step,
    output logic       Run,
    output logic       Running
);

    localparam int DW   = $clog2(DEBOUNCE);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } rep_state_t;

    // Bit 0 = HALT, bit 1 = STEP, bit 2 = RUN
    logic [2:0] raw_n;
    logic [2:0] deb;
    logic [2:0] deb_d;
    logic [2:0] press;

    assign raw_n = {BtnRun_n, BtnStep_n, BtnHalt_n};

    for (genvar i = 0; i < 3; i++) begin : g_btn
        logic [1:0]    sync;
        logic [DW-1:0] cnt;
        logic          level;

        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                sync  <= 2'b11;
                cnt   <= '0;
                level <= 1'b0;
            end else begin
                sync <= {sync[0], raw_n[i]};
                if (~sync[1] == level) begin
                    cnt <= '0;
                end else if (cnt == DW'(DEBOUNCE - 1)) begin
                    level <= ~sync[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign deb[i] = level;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) deb_d <= 3'b000;
        else        deb_d <= deb;
    end

    assign press = deb & ~deb_d;

    logic       is_halt;
    logic       ok;
    logic       rep_req;
    logic       step_press_fire;
    logic       step_fire;
    logic       run_fire;
    logic       halt_q;
    logic       step_q;
    logic       run_q;
    logic       running_q;
    rep_state_t state, state_nx;
    logic [RW-1:0] rcnt, rcnt_nx;

    assign is_halt = (CpuState == HALT_CODE);
    // A same-cycle HALT press outranks any step/run source
    assign ok              = is_halt & ~halt_q & ~press[0];
    assign step_press_fire = press[1] & ok;
    assign step_fire       = (press[1] | rep_req) & ok;
    assign run_fire        = press[2] & ok & ~press[1] & ~rep_req;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            halt_q    <= 1'b0;
            step_q    <= 1'b0;
            run_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            if (press[0])     halt_q <= 1'b1;
            else if (is_halt) halt_q <= 1'b0;
            step_q    <= step_fire;
            run_q     <= run_fire;
            running_q <= ~is_halt;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= S_IDLE;
            rcnt  <= '0;
        end else begin
            state <= state_nx;
            rcnt  <= rcnt_nx;
        end
    end

    // The request at the end of DELAY produces the first repeat pulse
    always_comb begin
        state_nx = state;
        rcnt_nx  = rcnt;
        rep_req  = 1'b0;
        if (!deb[1] || halt_q) begin
            state_nx = S_IDLE;
            rcnt_nx  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (step_press_fire) begin
                        state_nx = S_DELAY;
                        rcnt_nx  = '0;
                    end
                end
                S_DELAY: begin
                    if (rcnt == RW'(REPEAT_DELAY - 1)) begin
                        rep_req  = 1'b1;
                        state_nx = S_REPEAT;
                        rcnt_nx  = '0;
                    end else begin
                        rcnt_nx = rcnt + 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (rcnt == RW'(REPEAT_PERIOD - 1)) begin
                        rep_req = 1'b1;
                        rcnt_nx = '0;
                    end else begin
                        rcnt_nx = rcnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                    rcnt_nx  = '0;
                end
            endcase
        end
    end

    assign Halt    = halt_q;
    assign Step    = step_q;
    assign Run     = run_q;
    assign Running = running_q;

endmodule

`default_nettype wire

// File: tb/tb_panel_ctrl.sv
// ============================================================================
// tb_panel_ctrl: self-checking bench for panel_ctrl (DEBOUNCE=4, delay 32, period 8).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_panel_ctrl;

    localparam logic [2:0] C_HALT  = 3'b100;
    localparam logic [2:0] C_EXEC  = 3'b011;
    localparam logic [2:0] C_FETCH = 3'b001;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       BtnHalt_n = 1'b1;
    logic       BtnStep_n = 1'b1;
    logic       BtnRun_n = 1'b1;
    logic [2:0] CpuState = C_HALT;
    logic       Halt, Step, Run, Running;

    panel_ctrl #(
        .DEBOUNCE      (4),
        .REPEAT_DELAY  (32),
        .REPEAT_PERIOD (8),
        .HALT_CODE     (3'b100)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .BtnHalt_n (BtnHalt_n),
        .BtnStep_n (BtnStep_n),
        .BtnRun_n  (BtnRun_n),
        .CpuState  (CpuState),
        .Halt      (Halt),
        .Step      (Step),
        .Run       (Run),
        .Running   (Running)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       h, s, r;
        logic [2:0] cpu;
        int         hold;
        int         e_step, e_run, e_halt, e_first;
    } vec_t;

    typedef struct {
        int step, run, halt, first;
    } res_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_n   = 0;
    res_t sb[$];
    int   q_step[$];
    vec_t vecs[9];

    task automatic tick();
        @(posedge Clk);
        #1;
        edge_n++;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    initial begin
        int ns, nr, nh, first, overlap;
        res_t e;

        // h, s, r, cpu, hold, exp step/run/halt counts, exp first edge
        vecs[0] = '{1'b0, 1'b1, 1'b0, C_HALT, 10, 1, 0, 0,  7};
        vecs[1] = '{1'b0, 1'b1, 1'b0, C_HALT,  3, 0, 0, 0, -1};
        vecs[2] = '{1'b0, 1'b0, 1'b1, C_HALT, 10, 0, 1, 0,  7};
        vecs[3] = '{1'b0, 1'b1, 1'b1, C_HALT, 10, 1, 0, 0,  7};
        vecs[4] = '{1'b1, 1'b0, 1'b1, C_HALT, 10, 0, 0, 1,  7};
        vecs[5] = '{1'b0, 1'b1, 1'b0, C_EXEC, 10, 0, 0, 0, -1};
        vecs[6] = '{1'b0, 1'b0, 1'b1, C_EXEC, 10, 0, 0, 0, -1};
        vecs[7] = '{1'b1, 1'b0, 1'b0, C_EXEC,  3, 0, 0, 0, -1};
        vecs[8] = '{1'b1, 1'b1, 1'b0, C_HALT, 10, 0, 0, 1,  7};

        // Reset state
        repeat (3) tick();
        check("rst_halt", int'(Halt), 0);
        check("rst_step", int'(Step), 0);
        check("rst_run", int'(Run), 0);
        check("rst_running", int'(Running), 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (5) tick();

        // Table-driven single presses
        foreach (vecs[k]) begin
            CpuState = vecs[k].cpu;
            repeat (3) tick();
            sb.push_back('{vecs[k].e_step, vecs[k].e_run, vecs[k].e_halt, vecs[k].e_first});
            ns = 0; nr = 0; nh = 0; first = -1; overlap = 0;
            edge_n = 0;
            BtnHalt_n = ~vecs[k].h;
            BtnStep_n = ~vecs[k].s;
            BtnRun_n  = ~vecs[k].r;
            repeat (40) begin
                tick();
                if (edge_n == vecs[k].hold) begin
                    BtnHalt_n = 1'b1;
                    BtnStep_n = 1'b1;
                    BtnRun_n  = 1'b1;
                end
                ns += int'(Step);
                nr += int'(Run);
                nh += int'(Halt);
                if (first < 0 && (Step || Run || Halt)) first = edge_n;
                if ((Step && Run) || (Halt && (Step || Run))) overlap++;
            end
            e = sb.pop_front();
            check($sformatf("v%0d_step_cnt", k), ns, e.step);
            check($sformatf("v%0d_run_cnt", k), nr, e.run);
            check($sformatf("v%0d_halt_cnt", k), nh, e.halt);
            check($sformatf("v%0d_first_edge", k), first, e.first);
            check($sformatf("v%0d_overlap", k), overlap, 0);
        end

        // Held HALT request while core executes, cleared when core reaches HALT
        CpuState = C_EXEC;
        repeat (3) tick();
        edge_n = 0; ns = 0; nr = 0;
        BtnHalt_n = 1'b0;
        repeat (40) begin
            tick();
            if (edge_n == 10) BtnHalt_n = 1'b1;
            ns += int'(Step);
            nr += int'(Run);
            if (edge_n == 6)  check("halt_e6", int'(Halt), 0);
            if (edge_n == 7)  check("halt_e7", int'(Halt), 1);
            if (edge_n == 20) check("halt_e20", int'(Halt), 1);
            if (edge_n == 30) begin
                check("halt_e30", int'(Halt), 1);
                check("running_e30", int'(Running), 1);
                CpuState = C_HALT;
            end
            if (edge_n == 31) begin
                check("halt_e31", int'(Halt), 0);
                check("running_e31", int'(Running), 0);
            end
        end
        check("halt_seq_step", ns, 0);
        check("halt_seq_run", nr, 0);

        // Hold-to-repeat with pulses skipped while the core is fetching
        repeat (3) tick();
        q_step = {7, 39, 47, 63, 71, 79};
        edge_n = 0;
        BtnStep_n = 1'b0;
        repeat (100) begin
            tick();
            if (Step) begin
                if (q_step.size() == 0) check("repeat_extra", edge_n, -1);
                else check("repeat_edge", edge_n, q_step.pop_front());
            end
            if (edge_n == 52) CpuState = C_FETCH;
            if (edge_n == 54) check("running_fetch", int'(Running), 1);
            if (edge_n == 57) CpuState = C_HALT;
            if (edge_n == 78) BtnStep_n = 1'b1;
        end
        check("repeat_left", q_step.size(), 0);

        // Reset asserted mid-REPEAT while Step is high, then released with STEP held
        repeat (3) tick();
        edge_n = 0;
        BtnStep_n = 1'b0;
        repeat (47) tick();
        check("pre_reset_step", int'(Step), 1);
        Rst_n = 1'b0;
        #1;
        check("async_rst_step", int'(Step), 0);
        check("async_rst_halt", int'(Halt), 0);
        check("async_rst_run", int'(Run), 0);
        check("async_rst_running", int'(Running), 0);
        repeat (3) tick();
        @(negedge Clk);
        Rst_n = 1'b1;
        edge_n = 0; ns = 0; first = -1;
        repeat (30) begin
            tick();
            ns += int'(Step);
            if (first < 0 && Step) first = edge_n;
        end
        check("post_reset_step_cnt", ns, 1);
        check("post_reset_first", first, 7);
        BtnStep_n = 1'b1;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
